// File: rtl/scene_param_bank_if.sv
// scene_param_bank_if: groups the loader byte stream, frame strobe and renderer read port.
// master: loader/renderer side (drives writes, load_done, frame_start, rd_addr).
// slave : the parameter bank (drives rd_data, flags and the status bits).
interface scene_param_bank_if #(
  parameter int IDX_W = 6
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic             load_done;
  logic             frame_start;
  logic [4:0]       rd_addr;
  logic [15:0]      rd_data;
  logic [7:0]       flags;
  logic             params_valid;
  logic             overrun;
  logic             csum_err;

  modport master (
    output wr_en, wr_idx, wr_data, load_done, frame_start, rd_addr,
    input  rd_data, flags, params_valid, overrun, csum_err
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, load_done, frame_start, rd_addr,
    output rd_data, flags, params_valid, overrun, csum_err
  );
endinterface

// File: rtl/scene_param_bank.sv
// scene_param_bank: double-buffered 55-byte scene parameter bank fed by the UART loader.
// Ports: clk, reset (sync, active-high), bus (slave modport): byte writes, load_done,
//   frame_start, rd_addr in; rd_data (1-clk latency), flags, params_valid, overrun, csum_err out.
// Optional macro PARAM_CHECKSUM_EN: XOR-checks the block before it is allowed to swap in.
module scene_param_bank #(
  parameter int NBYTES = 55,
  parameter int IDX_W  = 6,
  parameter int NWORDS = 27
) (
  input logic               clk,
  input logic               reset,
  scene_param_bank_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [4:0]       NW       = 5'(NWORDS);

  logic [7:0]       bank0 [NBYTES];
  logic [7:0]       bank1 [NBYTES];
  logic             bank_sel;     // 0: bank0 active, bank1 shadow
  logic             pending;      // completed load waiting for a frame boundary
  logic             load_done_q;
  logic             rise;
  logic             in_range;
  logic             wr_ok;
  logic             csum_ok;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic [7:0]       act_lo;
  logic [7:0]       act_hi;
  logic [7:0]       act_flags;

  assign rise     = bus.load_done & ~load_done_q;
  assign in_range = bus.wr_idx <= LAST_IDX;
  // A write arriving while a swap is pending (including the swap cycle) is dropped.
  assign wr_ok    = bus.wr_en & in_range & ~pending;
  assign lo_idx   = IDX_W'({bus.rd_addr, 1'b0});
  assign hi_idx   = IDX_W'({bus.rd_addr, 1'b1});

  // Active-bank read mux; out-of-range word addresses read as zero.
  always_comb begin
    act_lo    = 8'h00;
    act_hi    = 8'h00;
    act_flags = bank_sel ? bank1[NBYTES-1] : bank0[NBYTES-1];
    if (bus.rd_addr < NW) begin
      act_lo = bank_sel ? bank1[lo_idx] : bank0[lo_idx];
      act_hi = bank_sel ? bank1[hi_idx] : bank0[hi_idx];
    end
  end

`ifdef PARAM_CHECKSUM_EN
  logic [7:0] acc;

  assign csum_ok = (acc == 8'h00);

  // Index 0 restarts the running XOR so each load is checked on its own bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= 8'h00;
      bus.csum_err <= 1'b0;
    end else begin
      if (wr_ok) begin
        acc <= (bus.wr_idx == '0) ? bus.wr_data : (acc ^ bus.wr_data);
      end
      if (rise && !pending && !csum_ok) begin
        bus.csum_err <= 1'b1;
      end
    end
  end
`else
  assign csum_ok      = 1'b1;
  assign bus.csum_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) begin
        bank0[i] <= 8'h00;
        bank1[i] <= 8'h00;
      end
      bank_sel         <= 1'b0;
      pending          <= 1'b0;
      load_done_q      <= 1'b0;
      bus.params_valid <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.rd_data      <= 16'h0000;
      bus.flags        <= 8'h00;
    end else begin
      load_done_q <= bus.load_done;

      if (wr_ok) begin
        if (bank_sel) begin
          bank0[bus.wr_idx] <= bus.wr_data;
        end else begin
          bank1[bus.wr_idx] <= bus.wr_data;
        end
      end

      if (bus.wr_en && in_range && pending) begin
        bus.overrun <= 1'b1;
      end

      // Swap has priority; a rise seen while already pending adds nothing.
      if (bus.frame_start && pending) begin
        bank_sel         <= ~bank_sel;
        pending          <= 1'b0;
        bus.params_valid <= 1'b1;
      end else if (rise && !pending && csum_ok) begin
        pending <= 1'b1;
      end

      // Reads use the pre-swap selection, so the swap cycle still returns old data.
      bus.rd_data <= {act_hi, act_lo};
      bus.flags   <= act_flags;
    end
  end

endmodule
